ascii_frame_encoder: RTL and testbench

ASCII_FRAME_ENCODER -- requirements
Module: ascii_frame_encoder

---
 rtl/ascii_frame_encoder_pkg.sv | 16 +
 rtl/ascii_frame_encoder_bin2bcd_seq.sv | 46 ++++
 rtl/ascii_frame_encoder.sv | 97 +++++++++
 tb/tb_ascii_frame_encoder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ascii_frame_encoder_pkg.sv
// ascii_frame_encoder_pkg: shared FSM states, ASCII constants and digit-count helper
package ascii_frame_encoder_pkg;
    typedef enum logic [2:0] {IDLE, CONVERT, SEND_PLUS, SEND_FIELD, SEND_TERM, DONE} state_t;
    localparam logic [7:0] PLUS  = 8'h2B;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] MINUS = 8'h2D;
    localparam logic [7:0] SEMI  = 8'h3B;
    localparam logic [7:0] AT    = 8'h40;
    localparam logic [7:0] ZERO  = 8'h30;
    localparam int BCD_DIGITS = 10;
    function automatic logic [4:0] digit_count(input logic [39:0] bcd);
        digit_count = 5'd1;
        for (int i = 1; i < BCD_DIGITS; i++)
            if (bcd[4*i +: 4] != 4'd0) digit_count = 5'(i + 1);
    endfunction
endpackage

// File: rtl/ascii_frame_encoder_bin2bcd_seq.sv
// bin2bcd_seq: 32-bit iterative double-dabble, one shift per cycle, done held until next load
module bin2bcd_seq
    import ascii_frame_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] bin,
    output logic [39:0] bcd,
    output logic        done
);
    logic [31:0] shift;
    logic [5:0]  cnt;
    logic        run;
    logic [39:0] adj;
    // add 3 to every digit of 5 or more before the next shift
    always_comb begin
        adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (bcd[4*i +: 4] > 4'd4) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    // 32 shift cycles, then one cycle to raise done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift <= '0;
            bcd   <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            done  <= 1'b0;
        end else if (load) begin
            shift <= bin;
            bcd   <= '0;
            cnt   <= '0;
            run   <= 1'b1;
            done  <= 1'b0;
        end else if (run) begin
            if (cnt == 6'd32) begin
                run  <= 1'b0;
                done <= 1'b1;
            end else begin
                {bcd, shift} <= {adj[38:0], shift, 1'b0};
                cnt <= cnt + 6'd1;
            end
        end
    end
endmodule

// File: rtl/ascii_frame_encoder.sv
// ascii_frame_encoder: formats a control-state or SNR value as an ASCII frame for a UART
module ascii_frame_encoder
    import ascii_frame_encoder_pkg::*;
#(
    parameter int SNR_FIELD = 3,
    parameter int SNR_MAX   = 99
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        frame_type,
    input  logic [31:0] value,
    input  logic        snr_neg,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);
    state_t      state, next;
    logic        type_q, neg_q, load, conv_done;
    logic [4:0]  pos, flen, ndig;
    logic [31:0] mag, conv_in;
    logic [39:0] bcd, shifted;
    logic [7:0]  field_byte;

    assign load    = state == IDLE && start;
    assign mag     = {25'd0, value[6:0]};
    assign conv_in = frame_type ? value : (mag > 32'(SNR_MAX) ? 32'(SNR_MAX) : mag);

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .bin     (conv_in),
        .bcd     (bcd),
        .done    (conv_done)
    );

    assign ndig    = digit_count(bcd);
    assign flen    = type_q ? ndig + 5'd1 : 5'(SNR_FIELD);
    assign shifted = bcd >> {flen - 5'd1 - pos, 2'b00};
    assign field_byte = pos >= flen - ndig ? ZERO + {4'd0, shifted[3:0]} :
                        (!type_q && neg_q && bcd != '0 && pos == flen - ndig - 5'd1) ? MINUS : SPACE;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next;
    end

    // captured frame attributes and field position counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            type_q <= 1'b0;
            neg_q  <= 1'b0;
            pos    <= '0;
        end else begin
            if (load) begin
                type_q <= frame_type;
                neg_q  <= snr_neg;
            end
            if (state == SEND_PLUS) pos <= '0;
            else if (state == SEND_FIELD && tx_ready) pos <= pos + 5'd1;
        end
    end

    // next-state and byte-stream outputs
    always_comb begin
        next     = state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = state != IDLE;
        done     = state == DONE;
        case (state)
            IDLE:       if (start) next = CONVERT;
            CONVERT:    if (conv_done) next = SEND_PLUS;
            SEND_PLUS: begin
                tx_valid = 1'b1;
                tx_data  = PLUS;
                if (tx_ready) next = SEND_FIELD;
            end
            SEND_FIELD: begin
                tx_valid = 1'b1;
                tx_data  = field_byte;
                if (tx_ready && pos == flen - 5'd1) next = SEND_TERM;
            end
            SEND_TERM: begin
                tx_valid = 1'b1;
                tx_data  = type_q ? AT : SEMI;
                if (tx_ready) next = DONE;
            end
            DONE:       next = IDLE;
            default:    next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ascii_frame_encoder.sv
// tb_ascii_frame_encoder: randomized frames checked against a string-level frame model
module tb_ascii_frame_encoder;
    localparam int SNR_FIELD = 3;
    localparam int SNR_MAX   = 99;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, frame_type = 1'b0, snr_neg = 1'b0, tx_ready = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, done;
    int          checks = 0, failures = 0;

    ascii_frame_encoder #(.SNR_FIELD(SNR_FIELD), .SNR_MAX(SNR_MAX)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .frame_type (frame_type),
        .value      (value),
        .snr_neg    (snr_neg),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string model(input bit typ, input logic [31:0] v, input bit neg);
        string f;
        int mag;
        if (typ) return {"+ ", $sformatf("%0d", v), "@"};
        mag = int'(v[6:0]) > SNR_MAX ? SNR_MAX : int'(v[6:0]);
        f = $sformatf("%0d", mag);
        if (neg && mag != 0) f = {"-", f};
        while (f.len() < SNR_FIELD) f = {" ", f};
        return {"+", f, ";"};
    endfunction

    // mode: 0 ready always, 1 ready one cycle in three, 2 random ready
    task automatic send_frame(input bit typ, input logic [31:0] v, input bit neg,
                              input int mode, input int glitch, input int abort_after);
        string      exp;
        logic [7:0] got[$];
        int         first = -1, last_push = -1, done_cyc = -1;
        logic       stall = 1'b0, any = 1'b0, rdy;
        logic [7:0] held = '0;
        exp = model(typ, v, neg);
        frame_type = typ;
        value      = v;
        snr_neg    = neg;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        frame_type = 1'($urandom);
        value      = $urandom;
        snr_neg    = 1'($urandom);
        chk("busy_rise", busy, 1);
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (stall) begin
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, held);
            end
            if (tx_valid && first < 0) first = cyc;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            rdy      = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom);
            tx_ready = rdy;
            stall    = tx_valid && !rdy;
            held     = tx_data;
            if (tx_valid && rdy) begin
                got.push_back(tx_data);
                last_push = cyc;
            end
            start = (cyc == glitch);
            if (abort_after > 0 && got.size() == abort_after) begin
                start = 1'b0;
                #2 reset_n = 1'b0;
                #1;
                chk("rst_valid", tx_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_data", tx_data, 0);
                @(posedge clk); #1;
                chk("rst_hold_valid", tx_valid, 0);
                @(negedge clk) reset_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("frame_done", done_cyc >= 0, 1);
        chk("first_valid_cycle", first, 34);
        chk("done_latency", done_cyc - last_push, 1);
        chk("frame_len", got.size(), exp.len());
        for (int i = 0; i < exp.len(); i++)
            chk($sformatf("byte%0d", i), i < got.size() ? got[i] : 8'h00, 32'(exp[i]));
        @(posedge clk); #1;
        chk("busy_fall", busy, 0);
        chk("done_pulse", done, 0);
        if (glitch >= 0) begin
            for (int k = 0; k < 50; k++) begin
                any = any | tx_valid | busy;
                @(posedge clk); #1;
            end
            chk("no_second_frame", any, 0);
        end
    endtask

    initial begin
        logic [31:0] r;
        bit          t;
        #12;
        chk("reset_valid", tx_valid, 0);
        chk("reset_data", tx_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        send_frame(1'b1, 32'd1234, 1'b0, 0, -1, 0);
        send_frame(1'b0, 32'd5, 1'b0, 0, -1, 0);
        send_frame(1'b0, 32'd7, 1'b1, 0, -1, 0);
        send_frame(1'b0, 32'd99, 1'b1, 0, -1, 0);
        send_frame(1'b0, 32'd150, 1'b0, 0, -1, 0);
        send_frame(1'b0, 32'd0, 1'b1, 0, -1, 0);
        send_frame(1'b1, 32'hFFFF_FFFF, 1'b0, 1, -1, 0);
        send_frame(1'b1, 32'd0, 1'b0, 0, 10, 0);
        send_frame(1'b1, 32'd987654321, 1'b0, 0, -1, 4);
        send_frame(1'b1, 32'd987654321, 1'b0, 0, -1, 0);
        for (int n = 0; n < 16; n++) begin
            r = $urandom;
            t = 1'($urandom);
            if (t) r = r >> $urandom_range(0, 31);
            send_frame(t, r, 1'($urandom), $urandom_range(0, 2), -1, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
